// File: rtl/up_down_bounded_counter.sv
// up_down_bounded_counter
//   Up/down counter with run-time inclusive bounds, a programmable step and a
//   parallel load. At the bounds it either saturates or wraps. Crossing a
//   bound gives a registered one-cycle Overflow/Underflow pulse.
//
// Ports
//   Clk         rising-edge clock
//   ResetN      asynchronous active-low reset
//   Enable      count this cycle
//   UpDownMode  1 = up, 0 = down
//   WrapMode    1 = wrap at bounds, 0 = saturate at bounds
//   Step        unsigned step magnitude
//   Load        synchronous parallel load strobe (clamped to the limits)
//   LoadValue   value for Load
//   MinLimit    inclusive lower bound
//   MaxLimit    inclusive upper bound
//   Output      registered count
//   AtMin       Output == MinLimit (combinational)
//   AtMax       Output == MaxLimit (combinational)
//   Overflow    registered pulse: up-count crossed MaxLimit
//   Underflow   registered pulse: down-count crossed MinLimit
//   ConfigError MinLimit > MaxLimit (combinational)
module up_down_bounded_counter #(
  parameter int unsigned       WIDTH       = 8,
  parameter int unsigned       STEP_WIDTH  = 4,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic                  Clk,
  input  logic                  ResetN,
  input  logic                  Enable,
  input  logic                  UpDownMode,
  input  logic                  WrapMode,
  input  logic [STEP_WIDTH-1:0] Step,
  input  logic                  Load,
  input  logic [WIDTH-1:0]      LoadValue,
  input  logic [WIDTH-1:0]      MinLimit,
  input  logic [WIDTH-1:0]      MaxLimit,
  output logic [WIDTH-1:0]      Output,
  output logic                  AtMin,
  output logic                  AtMax,
  output logic                  Overflow,
  output logic                  Underflow,
  output logic                  ConfigError
);

  // All arithmetic runs one bit wider so sums and differences never wrap
  // modulo 2^WIDTH. The bound checks rely on that.
  localparam logic [WIDTH:0] ONE_E = (WIDTH + 1)'(1);

  logic [WIDTH-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [WIDTH:0] cur_e, min_e, max_e, step_e, range_e;
  logic [WIDTH:0] sum_e, lo_e, exc_e;
  logic           cfg_err;

  assign cur_e   = {1'b0, out_q};
  assign min_e   = {1'b0, MinLimit};
  assign max_e   = {1'b0, MaxLimit};
  assign step_e  = {{(WIDTH + 1 - STEP_WIDTH){1'b0}}, Step};
  assign range_e = max_e - min_e + ONE_E;
  assign cfg_err = (MinLimit > MaxLimit);

  // Clamp a widened value into [MinLimit, MaxLimit].
  function automatic logic [WIDTH-1:0] clamp_to_limits(
    input logic [WIDTH:0] val_e,
    input logic [WIDTH:0] lo,
    input logic [WIDTH:0] hi
  );
    logic [WIDTH:0] res;
    if (val_e < lo)      res = lo;
    else if (val_e > hi) res = hi;
    else                 res = val_e;
    return res[WIDTH-1:0];
  endfunction

  always_comb begin
    out_d = out_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    sum_e = cur_e + step_e;
    // The down-count test "Output - Step >= Min" is rewritten as
    // "Output >= Min + Step" so it cannot underflow.
    lo_e  = min_e + step_e;
    exc_e = '0;

    if (cfg_err) begin
      // Inconsistent limits: freeze everything.
      out_d = out_q;
    end else if (Load) begin
      out_d = clamp_to_limits({1'b0, LoadValue}, min_e, max_e);
    end else if (Enable) begin
      if (cur_e < min_e || cur_e > max_e) begin
        // The limits moved under the count. Snap to the nearest bound and do not step this cycle.
        out_d = clamp_to_limits(cur_e, min_e, max_e);
      end else if (step_e == '0) begin
        out_d = out_q;
      end else if (UpDownMode) begin
        if (sum_e <= max_e) begin
          out_d = WIDTH'(sum_e);
        end else begin
          ovf_d = 1'b1;
          if (!WrapMode) begin
            out_d = MaxLimit;
          end else begin
            exc_e = sum_e - max_e - ONE_E;
            // An excess of a full range or more lands on the bound itself.
            out_d = (exc_e < range_e) ? WIDTH'(min_e + exc_e) : MinLimit;
          end
        end
      end else begin
        if (cur_e >= lo_e) begin
          out_d = WIDTH'(cur_e - step_e);
        end else begin
          unf_d = 1'b1;
          if (!WrapMode) begin
            out_d = MinLimit;
          end else begin
            exc_e = lo_e - cur_e - ONE_E;
            out_d = (exc_e < range_e) ? WIDTH'(max_e - exc_e) : MaxLimit;
          end
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      out_q <= RESET_VALUE;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign Output      = out_q;
  assign AtMin       = (out_q == MinLimit);
  assign AtMax       = (out_q == MaxLimit);
  assign Overflow    = ovf_q;
  assign Underflow   = unf_q;
  assign ConfigError = cfg_err;

endmodule

// File: tb/tb_up_down_bounded_counter.sv
module tb_up_down_bounded_counter;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned STEP_WIDTH = 4;

  logic                  Clk;
  logic                  ResetN;
  logic                  Enable;
  logic                  UpDownMode;
  logic                  WrapMode;
  logic [STEP_WIDTH-1:0] Step;
  logic                  Load;
  logic [WIDTH-1:0]      LoadValue;
  logic [WIDTH-1:0]      MinLimit;
  logic [WIDTH-1:0]      MaxLimit;
  logic [WIDTH-1:0]      Output;
  logic                  AtMin;
  logic                  AtMax;
  logic                  Overflow;
  logic                  Underflow;
  logic                  ConfigError;

  int checks;
  int failures;

  up_down_bounded_counter #(
    .WIDTH      (WIDTH),
    .STEP_WIDTH (STEP_WIDTH),
    .RESET_VALUE(8'd5)
  ) dut (
    .Clk        (Clk),
    .ResetN     (ResetN),
    .Enable     (Enable),
    .UpDownMode (UpDownMode),
    .WrapMode   (WrapMode),
    .Step       (Step),
    .Load       (Load),
    .LoadValue  (LoadValue),
    .MinLimit   (MinLimit),
    .MaxLimit   (MaxLimit),
    .Output     (Output),
    .AtMin      (AtMin),
    .AtMax      (AtMax),
    .Overflow   (Overflow),
    .Underflow  (Underflow),
    .ConfigError(ConfigError)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Check the count and both pulses together.
  task automatic expect_state(input string tag, input int unsigned o, input int unsigned ov,
                              input int unsigned un);
    check({tag, ".out"}, Output, o);
    check({tag, ".ovf"}, Overflow, ov);
    check({tag, ".unf"}, Underflow, un);
  endtask

  task automatic do_load(input int unsigned v);
    Load = 1'b1; LoadValue = v[WIDTH-1:0]; Enable = 1'b0;
    tick();
    Load = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    ResetN = 1'b0; Enable = 1'b0; UpDownMode = 1'b1; WrapMode = 1'b0;
    Step = '0; Load = 1'b0; LoadValue = '0; MinLimit = 8'd0; MaxLimit = 8'd255;
    #12;
    expect_state("reset", 5, 0, 0);
    check("reset.cfgerr", ConfigError, 0);
    ResetN = 1'b1;

    // Asynchronous reset in the middle of counting.
    do_load(37);
    expect_state("load37", 37, 0, 0);
    ResetN = 1'b0;
    #2;
    expect_state("async_reset", 5, 0, 0);
    @(negedge Clk);
    ResetN = 1'b1;
    Enable = 1'b1; UpDownMode = 1'b1; Step = 4'd1;
    tick();
    expect_state("resume", 6, 0, 0);

    // Saturate up.
    MinLimit = 8'd10; MaxLimit = 8'd20; WrapMode = 1'b0;
    do_load(18);
    check("sat.load", Output, 18);
    Enable = 1'b1; Step = 4'd3; UpDownMode = 1'b1;
    tick();
    expect_state("sat.up1", 20, 1, 0);
    check("sat.atmax", AtMax, 1);
    tick();
    expect_state("sat.up2", 20, 1, 0);
    Enable = 1'b0;
    tick();
    expect_state("sat.idle", 20, 0, 0);

    // Plain down-count with no crossing.
    Enable = 1'b1; UpDownMode = 1'b0;
    tick();
    expect_state("down.plain", 17, 0, 0);

    // Wrap up, then wrap down.
    WrapMode = 1'b1;
    do_load(19);
    Enable = 1'b1; UpDownMode = 1'b1; Step = 4'd4;
    tick();
    expect_state("wrap.up", 12, 1, 0);
    UpDownMode = 1'b0; Step = 4'd5;
    tick();
    expect_state("wrap.down", 18, 0, 1);

    // Wrap over the full 8-bit range.
    MinLimit = 8'd0; MaxLimit = 8'd255;
    do_load(250);
    Enable = 1'b1; UpDownMode = 1'b1; Step = 4'd10;
    tick();
    expect_state("wrap.full", 4, 1, 0);

    // Load takes priority over Enable and is clamped.
    MinLimit = 8'd10; MaxLimit = 8'd20;
    Load = 1'b1; Enable = 1'b1; LoadValue = 8'd50; Step = 4'd3;
    tick();
    expect_state("load.hi", 20, 0, 0);
    LoadValue = 8'd3;
    tick();
    expect_state("load.lo", 10, 0, 0);
    check("load.atmin", AtMin, 1);
    Load = 1'b0; Enable = 1'b0;

    // The limits move below the count. The count snaps to the bound without stepping.
    do_load(15);
    MaxLimit = 8'd12;
    Enable = 1'b1; UpDownMode = 1'b1; Step = 4'd1;
    tick();
    expect_state("oor.snap", 12, 0, 0);

    // Config error: the count is frozen.
    MinLimit = 8'd30; MaxLimit = 8'd12;
    #1;
    check("cfg.flag", ConfigError, 1);
    Load = 1'b1; LoadValue = 8'd20; Enable = 1'b1;
    tick();
    expect_state("cfg.load", 12, 0, 0);
    Load = 1'b0;
    tick();
    expect_state("cfg.en", 12, 0, 0);
    Enable = 1'b0;

    // Step of zero: the count holds.
    MinLimit = 8'd10; MaxLimit = 8'd20;
    do_load(15);
    Enable = 1'b1; Step = 4'd0; UpDownMode = 1'b1;
    tick();
    expect_state("step0", 15, 0, 0);

    // Min equals Max: every step fires a pulse.
    MinLimit = 8'd7; MaxLimit = 8'd7; WrapMode = 1'b1;
    do_load(7);
    Enable = 1'b1; Step = 4'd1; UpDownMode = 1'b1;
    tick();
    expect_state("eq.up1", 7, 1, 0);
    tick();
    expect_state("eq.up2", 7, 1, 0);
    UpDownMode = 1'b0;
    tick();
    expect_state("eq.down", 7, 0, 1);

    // An excess larger than the range lands on MinLimit.
    MinLimit = 8'd10; MaxLimit = 8'd13;
    do_load(10);
    Enable = 1'b1; Step = 4'd15; UpDownMode = 1'b1;
    tick();
    expect_state("bigstep", 10, 1, 0);

    // Saturate at MinLimit while already there.
    MinLimit = 8'd10; MaxLimit = 8'd20; WrapMode = 1'b0;
    do_load(10);
    Enable = 1'b1; Step = 4'd2; UpDownMode = 1'b0;
    tick();
    expect_state("sat.min", 10, 0, 1);
    Enable = 1'b0;
    tick();
    expect_state("sat.min.idle", 10, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
